// File: rtl/pow2_clock_div_ctrl.sv
// Power-of-two clock-enable sequencer: one tick every 2^cur_log2 cycles, with ratio
// changes applied only at period boundaries and separated by a tick-free gate interval.
module pow2_clock_div_ctrl #(
    parameter int unsigned MAX_LOG2    = 4,
    parameter int unsigned RESET_LOG2  = 2,
    parameter int unsigned GATE_CYCLES = 2,
    localparam int unsigned LW         = $clog2(MAX_LOG2 + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          io_req_valid,
    output logic          io_req_ready,
    input  logic [LW-1:0] io_req_bits_log2,
    output logic          io_tick,
    output logic [LW-1:0] io_cur_log2,
    output logic          io_busy
);

    localparam int unsigned CW = (MAX_LOG2 < 1) ? 1 : MAX_LOG2;
    localparam int unsigned GW = (GATE_CYCLES < 2) ? 1 : $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LOAD = (GATE_CYCLES == 0) ? '0 : GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StDrain, StGate} state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [LW-1:0] cur_log2;
    logic [LW-1:0] pend_log2;
    logic [GW-1:0] gcnt;
    logic          tick_q;

    logic [CW-1:0] mask;
    logic [CW-1:0] cnt_inc;
    logic [LW-1:0] req_clamped;
    logic          boundary;
    logic          accept;

    // Low cur_log2 bits of the counter set: 2^cur_log2 - 1.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(CW); i++) begin
            mask[i] = (i < int'(cur_log2));
        end
    end

    always_comb begin
        req_clamped = io_req_bits_log2;
        if (io_req_bits_log2 > LW'(MAX_LOG2)) begin
            req_clamped = LW'(MAX_LOG2);
        end
    end

    assign cnt_inc  = cnt + CW'(1);
    assign boundary = (state != StGate) && (cnt == mask);
    assign accept   = io_req_valid && io_req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StRun;
            cnt       <= '0;
            cur_log2  <= LW'(RESET_LOG2);
            pend_log2 <= LW'(RESET_LOG2);
            gcnt      <= '0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= boundary;
            case (state)
                StRun: begin
                    cnt <= boundary ? '0 : cnt_inc;
                    if (accept) begin
                        pend_log2 <= req_clamped;
                        if (req_clamped != cur_log2) begin
                            if (!boundary) begin
                                state <= StDrain;
                            end else if (GATE_CYCLES == 0) begin
                                // This boundary's tick still belongs to the old ratio.
                                cur_log2 <= req_clamped;
                                cnt      <= '0;
                            end else begin
                                state <= StGate;
                                gcnt  <= GATE_LOAD;
                            end
                        end
                    end
                end
                StDrain: begin
                    cnt <= boundary ? '0 : cnt_inc;
                    if (boundary) begin
                        if (GATE_CYCLES == 0) begin
                            state    <= StRun;
                            cur_log2 <= pend_log2;
                        end else begin
                            state <= StGate;
                            gcnt  <= GATE_LOAD;
                        end
                    end
                end
                StGate: begin
                    cnt <= '0;
                    if (gcnt == '0) begin
                        state    <= StRun;
                        cur_log2 <= pend_log2;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                default: begin
                    state <= StRun;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign io_req_ready = (state == StRun);
    assign io_busy      = (state != StRun);
    assign io_tick      = tick_q;
    assign io_cur_log2  = cur_log2;

endmodule

// File: doc/pow2_clock_div_ctrl.md
# pow2_clock_div_ctrl

Sequencer for the power-of-two clock division path: produces a one-cycle clock-enable tick every 2^N cycles of `clock`. It accepts ratio-change requests over a valid/ready handshake and applies each change only at a period boundary. A programmable gate interval, during which no tick is issued, separates the old ratio from the new one, so downstream logic never sees a truncated or merged period. It sits beside the fixed divide-by-4 chain and replaces hard-wired ratios wherever software-selectable division is needed.

## Interface
- `MAX_LOG2`, default 4: largest selectable log2 ratio (max divide = 2^MAX_LOG2); counter width = MAX_LOG2 bits (min 1).
- `RESET_LOG2`, default 2: log2 ratio after reset (divide-by-4); must be <= MAX_LOG2.
- `GATE_CYCLES`, default 2: tick-free cycles inserted between old and new ratio; 0 allowed.
- `LW`, derived: $clog2(MAX_LOG2+1), width of ratio fields.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `io_req_valid`  in  1  ratio-change request.
- `io_req_ready`  out  1  high only in RUN.
- `io_req_bits_log2`  in  LW  requested log2 ratio.
- `io_tick`  out  1  registered one-cycle enable pulse, once per period.
- `io_cur_log2`  out  LW  ratio currently in effect.
- `io_busy`  out  1  high in DRAIN or GATE.

## Operation
- Registers: state {RUN, DRAIN, GATE}, cnt (MAX_LOG2 bits), cur_log2, pend_log2, gcnt, tick_q.
- mask = 2^cur_log2 - 1; boundary = (state != GATE) && (cnt == mask).
- RUN/DRAIN: cnt increments each cycle and wraps to 0 on boundary. tick_q <= boundary.
- GATE: cnt held at 0; tick_q <= 0.
- Accept = io_req_valid && io_req_ready. pend_log2 <= min(io_req_bits_log2, MAX_LOG2). Out-of-range requests are clamped, not rejected.
- Accept with clamped value == cur_log2: no-op. Stay RUN; cnt and ticks undisturbed.
- Accept with a different value, in RUN:
  - Not on a boundary cycle: go to DRAIN.
  - On a boundary cycle, or from DRAIN when a boundary occurs: that boundary's tick belongs to the old ratio. Then go to GATE with gcnt = GATE_CYCLES-1, or go directly to RUN when GATE_CYCLES = 0.
- GATE: if gcnt == 0, go to RUN; else decrement gcnt.
- Entering RUN from GATE/DRAIN: cur_log2 <= pend_log2 and cnt <= 0 in the same edge.
- io_req_ready = (state == RUN). Requests presented while busy are ignored and must be held by the requester.
- io_busy = (state != RUN).

## Timing
- Reset values: state RUN, cnt 0, cur_log2 = RESET_LOG2, tick_q 0, io_tick 0, io_busy 0, io_req_ready 1 (combinational from state), io_cur_log2 = RESET_LOG2.
- Numbering: cycle 0 is the first cycle with reset low. The first tick is high in cycle 2^RESET_LOG2; later ticks follow every 2^cur_log2 cycles.
- log2 = 0: io_tick high every cycle while in RUN/DRAIN.
- Switch latency, request accepted at cnt = c under old mask M:
  - The last old tick is in cycle T+(M-c)+1.
  - GATE occupies the next GATE_CYCLES cycles.
  - RUN resumes at cycle R. The first new tick is in cycle R+2^new; io_cur_log2 changes at R.
- Reset asserted in any state at any time: full return to reset values next cycle. The pending request is discarded and no tick is issued.

## Test plan
- Reset with defaults, no requests -> io_tick high in cycles 4, 8, 12, 16; io_cur_log2 = 2; io_busy = 0 throughout.
- Request log2=0 accepted in cycle 5 (cnt=1):
  - DRAIN in 6–7, tick in 8.
  - GATE in 8–9, io_busy high in 6–9.
  - RUN at 10 with io_cur_log2 = 0; ticks every cycle from 11.
- Request log2=3 accepted in cycle 3 (boundary):
  - Tick in 4, no DRAIN, GATE in 4–5.
  - RUN at 6; next tick in 14, then 22.
- Request log2=2 (equal to current) in cycle 1, and request log2=7 with MAX_LOG2=4:
  - Equal request: ticks stay at 4, 8; io_busy never asserts.
  - Out-of-range request: clamped, and io_cur_log2 settles at 4.
- io_req_valid held high with changing bits during DRAIN/GATE -> io_req_ready = 0; bits ignored; only the accepted value is applied.
- Reset pulsed during GATE; separately, GATE_CYCLES=0 build -> no tick in the reset cycle, ticks resume at 4, 8 with io_cur_log2 = 2; with GATE_CYCLES=0, RUN follows the final old tick directly.
